// File: rtl/conv_op.sv
// Single-channel 3x3 convolution engine (stride 1, valid padding, signed Qm.FRAC).
// Define CONV_OP_SATURATE_EN to clamp results to the DW-bit range instead of wrapping.

module conv_op_pe #(
  parameter int DW   = 16,
  parameter int FRAC = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [9*DW-1:0] win,
  input  logic [9*DW-1:0] kernel,
  output logic [9*DW-1:0] x,
  output logic [DW-1:0]   result
);

  localparam int AW = 2*DW + 4;

  logic signed [2*DW-1:0] prod [9];
  logic signed [AW-1:0]   acc;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) x <= '0;
    else if (load) x <= win;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc = '0;
    for (int i = 0; i < 9; i++) begin
      prod[i] = (2*DW)'($signed(x[i*DW +: DW])) * (2*DW)'($signed(kernel[i*DW +: DW]));
      acc     = acc + AW'(prod[i]);
    end
  end

`ifdef CONV_OP_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [AW-1:0] shifted;

  always_comb begin
    shifted = acc >>> FRAC;
    if (shifted > SAT_MAX)      result = {1'b0, {(DW-1){1'b1}}};
    else if (shifted < SAT_MIN) result = {1'b1, {(DW-1){1'b0}}};
    else                        result = shifted[DW-1:0];
  end
`else
  assign result = DW'(acc >>> FRAC);
`endif

endmodule

module conv_op #(
  parameter int IMG_W = 7,
  parameter int IMG_H = 7,
  parameter int DW    = 16,
  parameter int FRAC  = 4
) (
  input  logic                                 en,
  output logic                                 complete,
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [IMG_W*IMG_H*DW-1:0]            X,
  input  logic [9*DW-1:0]                      kernel,
  output logic [(IMG_W-2)*(IMG_H-2)*DW-1:0]    out
);

  localparam int OUT_W = IMG_W - 2;
  localparam int OUT_H = IMG_H - 2;
  localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(OUT_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(OUT_W - 1);

  typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

  state_t        state, nxt_state;
  logic [RW-1:0] row, nxt_row, wr;
  logic [CW-1:0] col, nxt_col, wc;
  logic          load, wr_en;
  logic [9*DW-1:0] win;
  logic [DW-1:0]   result;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= LOAD;
    else       state <= nxt_state;
  end

  // The counters always name the window currently held in PE; nxt_* name the one to load.
  always_comb begin
    nxt_state = state;
    nxt_row   = row;
    nxt_col   = col;
    load      = 1'b0;
    wr_en     = 1'b0;
    case (state)
      LOAD: if (en) begin
        load      = 1'b1;
        nxt_state = RUN;
      end
      RUN: if (en) begin
        wr_en = 1'b1;
        if (row == ROW_LAST && col == COL_LAST) begin
          nxt_state = DONE;
        end else begin
          load = 1'b1;
          if (col == COL_LAST) begin
            nxt_col = '0;
            nxt_row = row + RW'(1);
          end else begin
            nxt_col = col + CW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign wr = (state == LOAD) ? row : nxt_row;
  assign wc = (state == LOAD) ? col : nxt_col;

  always_comb begin
    win = '0;
    for (int kr = 0; kr < 3; kr++)
      for (int kc = 0; kc < 3; kc++)
        win[(kr*3 + kc)*DW +: DW] = X[((int'(wr) + kr)*IMG_W + int'(wc) + kc)*DW +: DW];
  end

  conv_op_pe #(.DW(DW), .FRAC(FRAC)) PE (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .win    (win),
    .kernel (kernel),
    .x      (),
    .result (result)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      row <= '0;
      col <= '0;
    end else if (wr_en) begin
      row <= nxt_row;
      col <= nxt_col;
    end
  end

  // NOTE: the result map is a register bank, not a RAM, so it is cleared by reset like any flop.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)      out <= '0;
    else if (wr_en) out[(int'(row)*OUT_W + int'(col))*DW +: DW] <= result;
  end

  assign complete = (state == DONE);

endmodule

// File: tb/tb_conv_op.sv
// Scoreboard bench for conv_op: directed frames push expected maps, a monitor
// compares the whole map and the completion edge when complete rises.

module tb_conv_op;

  localparam int IMG_W = 7;
  localparam int IMG_H = 7;
  localparam int DW    = 16;
  localparam int OUT_W = 5;
  localparam int OUT_H = 5;
  localparam int NPIX  = OUT_W * OUT_H;
  localparam int XW    = IMG_W * IMG_H * DW;
  localparam int KW    = 9 * DW;
  localparam int MW    = NPIX * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          complete;
  logic [XW-1:0] X = '0;
  logic [KW-1:0] kernel = '0;
  logic [MW-1:0] out;

  conv_op dut (
    .en       (en),
    .complete (complete),
    .clk      (clk),
    .rst_n    (rst_n),
    .X        (X),
    .kernel   (kernel),
    .out      (out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_cnt;
  int seen = 0;

  typedef struct {
    logic [MW-1:0] map;
    int            edge_n;
    int            id;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  // Monitor: one expected map is consumed per rising edge of complete.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (complete && !prev) begin
        if (sb_q.size() == 0) begin
          check("unexpected_complete", 64'(seen), 64'(seen + 1));
        end else begin
          e = sb_q.pop_front();
          for (int p = 0; p < NPIX; p++)
            check($sformatf("map%0d_px%0d", e.id, p), 64'(out[p*DW +: DW]), 64'(e.map[p*DW +: DW]));
          check($sformatf("map%0d_complete_edge", e.id), 64'(edge_cnt), 64'(e.edge_n));
        end
        seen++;
      end
      prev = complete;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_px(input int r, input int c, input logic [DW-1:0] v);
    X[(r*IMG_W + c)*DW +: DW] = v;
  endtask

  task automatic push_exp(input logic [MW-1:0] m, input int e, input int id);
    exp_t t;
    t.map    = m;
    t.edge_n = e;
    t.id     = id;
    sb_q.push_back(t);
  endtask

  // Hold reset two cycles, then release on a falling edge with en high: next rising edge is edge 1.
  task automatic start_frame();
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b1;
  endtask

  task automatic wait_seen(input int target, input string name);
    int n;
    n = 0;
    while (seen < target && n < 80) begin
      @(posedge clk);
      n++;
    end
    check({name, "_finished"}, 64'(seen), 64'(target));
  endtask

  task automatic load_t1_stim();
    X      = '0;
    kernel = '0;
    for (int i = 0; i < 9; i++) kernel[i*DW +: DW] = 16'h0010;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++) set_px(r, c, 16'h0010);
  endtask

  function automatic logic [MW-1:0] t1_map();
    logic [MW-1:0] m;
    m = '0;
    m[0*DW +: DW] = 16'h0060;
    m[1*DW +: DW] = 16'h0040;
    m[2*DW +: DW] = 16'h0020;
    m[5*DW +: DW] = 16'h0030;
    m[6*DW +: DW] = 16'h0020;
    m[7*DW +: DW] = 16'h0010;
    return m;
  endfunction

  initial begin
    logic [MW-1:0] m;
    logic [DW-1:0] v;

    // Reset pulse: held 20 ns, released on the falling edge at t=20.
    #12;
    check("rst_held_out", 64'(|out), 64'(0));
    check("rst_held_complete", 64'(complete), 64'(0));
    check("rst_held_pe_x", 64'(|dut.PE.x), 64'(0));
    #8;
    rst_n = 1'b0;
    #1;
    check("rst_rel_out", 64'(|out), 64'(0));
    check("rst_rel_complete", 64'(complete), 64'(0));
    check("rst_rel_pe_x", 64'(|dut.PE.x), 64'(0));

    // With en low nothing may be loaded even though X is live.
    load_t1_stim();
    repeat (3) @(posedge clk);
    #1;
    check("idle_en_low_pe_x", 64'(|dut.PE.x), 64'(0));
    check("idle_en_low_complete", 64'(complete), 64'(0));

    // Frame 1: basic map, complete on edge 26.
    push_exp(t1_map(), 26, 1);
    start_frame();
    wait_seen(1, "frame1");

    // DONE ignores en and freezes out.
    repeat (3) begin
      @(negedge clk); en = ~en;
    end
    @(negedge clk);
    check("done_complete_held", 64'(complete), 64'(1));
    check("done_out_frozen", 64'(out !== t1_map()), 64'(0));

    // Frame 2: five-edge stall after edge 10, complete delayed to edge 31.
    push_exp(t1_map(), 31, 2);
    start_frame();
    repeat (10) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    en = 1'b1;
    wait_seen(2, "frame2_stall");

    // Frame 3: full-scale inputs, saturate or wrap.
    for (int i = 0; i < IMG_W*IMG_H; i++) X[i*DW +: DW] = 16'h7FFF;
    for (int i = 0; i < 9; i++) kernel[i*DW +: DW] = 16'h7FFF;
`ifdef CONV_OP_SATURATE_EN
    v = 16'h7FFF;
`else
    v = 16'h7000;
`endif
    for (int p = 0; p < NPIX; p++) m[p*DW +: DW] = v;
    push_exp(m, 26, 3);
    start_frame();
    wait_seen(3, "frame3_fullscale");

    // Frame 4: centre tap -1.0 on a ramp image.
    kernel = '0;
    kernel[4*DW +: DW] = 16'hFFF0;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) set_px(r, c, DW'((r*IMG_W + c) << 4));
    for (int r = 0; r < OUT_H; r++)
      for (int c = 0; c < OUT_W; c++)
        m[(r*OUT_W + c)*DW +: DW] = DW'(-(((r+1)*IMG_W + c + 1) << 4));
    push_exp(m, 26, 4);
    start_frame();
    wait_seen(4, "frame4_ramp");

    // Frame 5: reset asserted after edge 10 aborts; the rerun reproduces the map.
    load_t1_stim();
    start_frame();
    repeat (10) @(posedge clk);
    #1;
    check("pre_abort_out00", 64'(out[0 +: DW]), 64'(16'h0060));
    #1;
    rst_n = 1'b1;
    #1;
    check("abort_out_cleared", 64'(|out), 64'(0));
    check("abort_complete", 64'(complete), 64'(0));
    check("abort_pe_x", 64'(|dut.PE.x), 64'(0));
    push_exp(t1_map(), 26, 5);
    start_frame();
    wait_seen(5, "frame5_rerun");

    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
